avr_spi_reg_bridge: RTL and testbench

- SPI slave (mode 0, MSB first) on the AVR SPI pins. Turns framed SPI transactions into single-word or burst read/write cycles on a parametrised req/ack register bus.
- Generalises the fixed 32-bit addr/data placeholders in the board top. Address and data widths are parameters, and the block adds burst auto-increment.
- Instantiated in the board top. The top turns spi_miso/spi_miso_oe into the tri-stated pin.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 49 ++++
 rtl/avr_spi_reg_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_avr_spi_reg_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the AVR SPI to register-bus bridge: FSM encoding and
// command byte layout.
package bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_WBUS,
        ST_RDUMMY,
        ST_RDATA,
        ST_IGNORE,
        ST_DRAIN
    } state_t;

    localparam int         CMD_W_BIT     = 7;
    localparam int         CMD_INC_BIT   = 6;
    localparam logic [5:0] CMD_RSVD_MASK = 6'h3F;

    function automatic logic cmd_rsvd_bad(input logic [7:0] cmd);
        return (cmd[5:0] & CMD_RSVD_MASK) != 6'd0;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and derives one-cycle
// edge pulses for sck and ss from the synchronised levels.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ss,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_ss,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ss_fall,
    output logic o_ss_rise
);

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_prev;
    logic                   r_sck_prev;

    // ss resets deasserted so leaving reset never looks like a frame start
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ss_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_prev   <= 1'b1;
            r_sck_prev  <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign o_ss       = r_ss_sync[SYNC_STAGES-1];
    assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign o_sck_rise =  r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
    assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] &  r_sck_prev;
    assign o_ss_fall  = ~r_ss_sync[SYNC_STAGES-1]  &  r_ss_prev;
    assign o_ss_rise  =  r_ss_sync[SYNC_STAGES-1]  & ~r_ss_prev;

endmodule

// File: rtl/avr_spi_reg_bridge.sv
// SPI mode-0 slave that turns command/address/data frames from the AVR into
// single or auto-incrementing burst cycles on a req/ack register bus.
module avr_spi_reg_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_ss,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              frame_err
);

    localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    logic w_ss, w_mosi, w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ss       (spi_ss),
        .i_sck      (spi_sck),
        .i_mosi     (spi_mosi),
        .o_ss       (w_ss),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ss_fall  (w_ss_fall),
        .o_ss_rise  (w_ss_rise)
    );

    state_t            r_state;
    logic              r_cmd_w, r_cmd_inc;
    logic [5:0]        r_bit_cnt;
    logic [SW-2:0]     r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rbuf;
    logic              r_bus_req, r_bus_we, r_miso, r_frame_err;
    logic              r_rbuf_vld, r_discard, r_pf_pend;

    logic [SW-1:0]     w_shift_nxt;
    logic [5:0]        w_phase_len;
    logic              w_active, w_last, w_rd_ack, w_word_avail;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] w_next_addr;

    always_comb begin
        w_shift_nxt = {r_shift, w_mosi};
        w_phase_len = 6'd8;
        w_active    = 1'b1;
        case (r_state)
            ST_CMD, ST_RDUMMY:           w_phase_len = 6'd8;
            ST_ADDR:                     w_phase_len = 6'(ADDR_W);
            ST_WDATA, ST_WBUS, ST_RDATA: w_phase_len = 6'(DATA_W);
            default:                     w_active    = 1'b0;
        endcase
        w_last       = (r_bit_cnt == w_phase_len - 6'd1);
        w_rd_ack     = r_bus_req && bus_ack && !r_bus_we && !r_discard;
        w_word_avail = r_rbuf_vld || w_rd_ack;
        w_word       = w_rd_ack ? bus_rdata : r_rbuf;
        w_next_addr  = r_cmd_inc ? r_addr + ADDR_W'(1) : r_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_w     <= 1'b0;
            r_cmd_inc   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_miso      <= 1'b1;
            r_frame_err <= 1'b0;
            r_rbuf_vld  <= 1'b0;
            r_discard   <= 1'b0;
            r_pf_pend   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (r_bus_req && bus_ack) begin
                r_bus_req <= 1'b0;
                r_discard <= 1'b0;
                if (w_rd_ack) begin
                    r_rbuf     <= bus_rdata;
                    r_rbuf_vld <= 1'b1;
                end
            end

            // A prefetch that found the bus busy goes out once it frees up
            if (r_pf_pend && !r_bus_req && r_state == ST_RDATA) begin
                r_bus_req  <= 1'b1;
                r_bus_we   <= 1'b0;
                r_bus_addr <= r_addr;
                r_pf_pend  <= 1'b0;
            end

            if (w_sck_rise && w_active) begin
                r_shift   <= w_shift_nxt[SW-2:0];
                r_bit_cnt <= w_last ? 6'd0 : r_bit_cnt + 6'd1;
            end

            if (w_sck_fall && r_state == ST_RDATA) begin
                r_miso <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= ST_CMD;
                        r_bit_cnt  <= '0;
                        r_miso     <= 1'b0;
                        r_tx       <= '0;
                        r_rbuf_vld <= 1'b0;
                        r_discard  <= 1'b0;
                        r_pf_pend  <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise && w_last) begin
                        r_cmd_w   <= w_shift_nxt[CMD_W_BIT];
                        r_cmd_inc <= w_shift_nxt[CMD_INC_BIT];
                        if (cmd_rsvd_bad(w_shift_nxt[7:0])) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_IGNORE;
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && w_last) begin
                        r_addr <= w_shift_nxt[ADDR_W-1:0];
                        if (r_cmd_w) begin
                            r_state <= ST_WDATA;
                        end else begin
                            r_state    <= ST_RDUMMY;
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= w_shift_nxt[ADDR_W-1:0];
                            r_rbuf_vld <= 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_sck_rise && w_last) begin
                        r_state     <= ST_WBUS;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b1;
                        r_bus_addr  <= r_addr;
                        r_bus_wdata <= w_shift_nxt[DATA_W-1:0];
                    end
                end
                ST_WBUS: begin
                    if (bus_ack) begin
                        r_state <= ST_WDATA;
                        r_addr  <= w_next_addr;
                    end
                end
                // Word boundary: hand out the fetched word or all-ones if it missed the deadline
                ST_RDUMMY, ST_RDATA: begin
                    if (w_sck_rise && w_last) begin
                        r_state    <= ST_RDATA;
                        r_rbuf_vld <= 1'b0;
                        r_addr     <= w_next_addr;
                        if (w_word_avail) begin
                            r_tx <= w_word;
                        end else begin
                            r_tx        <= '1;
                            r_frame_err <= 1'b1;
                            if (r_bus_req && !bus_ack)
                                r_discard <= 1'b1;
                        end
                        if (r_bus_req) begin
                            r_pf_pend <= 1'b1;
                        end else begin
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= w_next_addr;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus_ack)
                        r_state <= ST_IDLE;
                end
                default: ;
            endcase

            // End of frame: finish any outstanding bus cycle before going idle
            if (w_ss_rise && r_state != ST_IDLE) begin
                r_pf_pend <= 1'b0;
                if (r_bus_req && !bus_ack) begin
                    r_state <= ST_DRAIN;
                end else begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = ~w_ss;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign busy        = (r_state != ST_IDLE);
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_avr_spi_reg_bridge.sv
// Scoreboard bench for avr_spi_reg_bridge: expected bus cycles are queued as
// frames are driven and checked as the bus model acknowledges them.
module tb_avr_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_ack = 1'b0;
    logic        busy, frame_err;

    avr_spi_reg_bridge #(.ADDR_W(16), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_ss      (spi_ss),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_txn_t;

    bus_txn_t    exp_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    int          req_rises = 0;
    int          bus_cycles = 0;
    logic        req_q = 1'b0;
    int          ack_dly = 2;
    logic        hold_all = 1'b0;
    logic        hold_en = 1'b0;
    logic [15:0] hold_addr = 16'h0000;
    logic [7:0]  rx;
    int          e0, r0, c0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h5A;
            16'h0011: return 8'h3C;
            16'h0020: return 8'h77;
            default:  return a[7:0] ^ 8'h96;
        endcase
    endfunction

    task automatic sb_pop();
        bus_txn_t e;
        bus_cycles++;
        if (exp_q.size() == 0) begin
            chk("bus_unexpected", 32'(bus_addr), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(e.we));
            chk("bus_addr", 32'(bus_addr), 32'(e.addr));
            if (e.we)
                chk("bus_wdata", 32'(bus_wdata), 32'(e.data));
        end
    endtask

    // Bus slave: acknowledges ack_dly cycles after req unless held off
    initial begin
        logic in_prog;
        int   wait_cnt;
        in_prog  = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
                in_prog = 1'b0;
            end else if (bus_req && rst_n) begin
                if (!in_prog) begin
                    in_prog  = 1'b1;
                    wait_cnt = 0;
                end
                wait_cnt++;
                if (wait_cnt >= ack_dly && !hold_all && !(hold_en && bus_addr == hold_addr)) begin
                    bus_ack   = 1'b1;
                    bus_rdata = mem_rd(bus_addr);
                    sb_pop();
                end
            end else begin
                in_prog = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (bus_req && !req_q) req_rises <= req_rises + 1;
        req_q <= bus_req;
    end

    task automatic push(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus_txn_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (5) @(negedge clk);
            rxb[i]  = spi_miso;
            spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (5) @(negedge clk);
        spi_ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !bus_req; i++) @(negedge clk);
        chk(tag, 32'(bus_req), 32'd1);
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_miso"},  32'(spi_miso), 32'd1);
        chk({pfx, "_oe"},    32'(spi_miso_oe), 32'd0);
        chk({pfx, "_req"},   32'(bus_req), 32'd0);
        chk({pfx, "_we"},    32'(bus_we), 32'd0);
        chk({pfx, "_addr"},  32'(bus_addr), 32'd0);
        chk({pfx, "_wdata"}, 32'(bus_wdata), 32'd0);
        chk({pfx, "_busy"},  32'(busy), 32'd0);
        chk({pfx, "_ferr"},  32'(frame_err), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single write
        e0 = err_cnt; c0 = bus_cycles;
        push(1'b1, 16'h1234, 8'hA5);
        ss_low();
        chk("w1_oe", 32'(spi_miso_oe), 32'd1);
        chk("w1_busy", 32'(busy), 32'd1);
        xfer(8'h80, 8, rx); xfer(8'h12, 8, rx); xfer(8'h34, 8, rx); xfer(8'hA5, 8, rx);
        ss_high();
        wait_idle("w1_idle", 20);
        chk("w1_cycles", 32'(bus_cycles - c0), 32'd1);
        chk("w1_ferr", 32'(err_cnt - e0), 32'd0);

        // Burst write across the top of the address space
        c0 = bus_cycles;
        push(1'b1, 16'hFFFF, 8'h11);
        push(1'b1, 16'h0000, 8'h22);
        ss_low();
        xfer(8'hC0, 8, rx); xfer(8'hFF, 8, rx); xfer(8'hFF, 8, rx);
        xfer(8'h11, 8, rx); xfer(8'h22, 8, rx);
        ss_high();
        wait_idle("w2_idle", 20);
        chk("w2_cycles", 32'(bus_cycles - c0), 32'd2);

        // Burst read with the third prefetch held past ss rise
        ack_dly = 3; hold_en = 1'b1; hold_addr = 16'h0012;
        push(1'b0, 16'h0010, 8'h00);
        push(1'b0, 16'h0011, 8'h00);
        push(1'b0, 16'h0012, 8'h00);
        ss_low();
        xfer(8'h40, 8, rx);
        chk("r_cmd_miso", 32'(rx), 32'h00);
        xfer(8'h00, 8, rx); xfer(8'h10, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        chk("r_byte0", 32'(rx), 32'h5A);
        xfer(8'h00, 8, rx);
        chk("r_byte1", 32'(rx), 32'h3C);
        ss_high();
        chk("r_drain_busy", 32'(busy), 32'd1);
        chk("r_drain_req", 32'(bus_req), 32'd1);
        chk("r_drain_addr", 32'(bus_addr), 32'h0012);
        hold_en = 1'b0;
        wait_idle("r_idle", 20);
        chk("r_q_empty", 32'(exp_q.size()), 32'd0);

        // Read whose acknowledge arrives far too late
        ack_dly = 200;
        push(1'b0, 16'h0020, 8'h00);
        e0 = err_cnt;
        ss_low();
        xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h20, 8, rx);
        xfer(8'h00, 8, rx);
        chk("late_ferr", 32'(err_cnt - e0), 32'd1);
        chk("late_req_held", 32'(bus_req), 32'd1);
        xfer(8'h00, 8, rx);
        chk("late_miso", 32'(rx), 32'hFF);
        ss_high();
        chk("late_drain", 32'(busy), 32'd1);
        wait_idle("late_idle", 300);
        chk("late_q_empty", 32'(exp_q.size()), 32'd0);
        ack_dly = 2;

        // Reserved command bits set
        e0 = err_cnt; r0 = req_rises;
        ss_low();
        xfer(8'h3F, 8, rx);
        chk("bad_cmd_miso", 32'(rx), 32'h00);
        chk("bad_ferr", 32'(err_cnt - e0), 32'd1);
        chk("bad_miso_now", 32'(spi_miso), 32'd0);
        chk("bad_busy", 32'(busy), 32'd1);
        xfer(8'h80, 8, rx);
        ss_high();
        wait_idle("bad_idle", 20);
        chk("bad_noreq", 32'(req_rises - r0), 32'd0);

        // Write aborted after 12 bits
        e0 = err_cnt; r0 = req_rises;
        ss_low();
        xfer(8'h80, 8, rx); xfer(8'h12, 4, rx);
        ss_high();
        wait_idle("abort_idle", 20);
        chk("abort_noreq", 32'(req_rises - r0), 32'd0);
        chk("abort_noerr", 32'(err_cnt - e0), 32'd0);

        // Reset while a write cycle is outstanding
        hold_all = 1'b1;
        ss_low();
        xfer(8'h80, 8, rx); xfer(8'h12, 8, rx); xfer(8'h34, 8, rx); xfer(8'hA5, 8, rx);
        wait_req("wbus_req", 20);
        chk("wbus_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid");
        rst_n = 1'b1;
        hold_all = 1'b0;
        ss_high();
        wait_idle("mid_idle", 20);

        c0 = bus_cycles;
        push(1'b1, 16'h4321, 8'h5C);
        ss_low();
        xfer(8'h80, 8, rx); xfer(8'h43, 8, rx); xfer(8'h21, 8, rx); xfer(8'h5C, 8, rx);
        ss_high();
        wait_idle("post_idle", 20);
        chk("post_cycles", 32'(bus_cycles - c0), 32'd1);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
